// File: rtl/sipo_deserializer.sv
// sipo_deserializer
//   Serial-in, parallel-out receiver. Collects an MSB-first bit stream into
//   WIDTH-bit words and hands each completed word downstream over a
//   valid/ready handshake. A one-word holding buffer lets reception continue
//   while the consumer stalls. A word that completes while the buffer is
//   still occupied is dropped and flagged by the sticky overflow bit.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   serial_in  serial data bit, MSB of each word first
//   in_valid   qualifies serial_in
//   sync       framing realign; discards any partial word
//   data_out   last completed word, stable while out_valid=1
//   out_valid  data_out holds an undelivered word
//   out_ready  consumer accepts data_out when out_valid=1
//   busy       a partial word is in progress
//   overflow   sticky: a completed word was dropped (cleared only by reset)

module sipo_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             in_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] word_buf;
    logic             valid_q;
    logic             overflow_q;

    logic [WIDTH-1:0] word;
    logic             complete;
    logic             buf_free;
    logic             drain;

    always_comb begin
        word     = {sr[WIDTH-2:0], serial_in};
        // A sync bit always starts a new word, so it can never complete one.
        complete = in_valid && !sync && (cnt == CNT_LAST);
        drain    = valid_q && out_ready;
        // The buffer may be drained and refilled on the same edge.
        buf_free = !valid_q || out_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr         <= '0;
            cnt        <= '0;
            word_buf   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (sync) begin
                if (in_valid) begin
                    sr  <= {{(WIDTH-1){1'b0}}, serial_in};
                    cnt <= CW'(1);
                end else begin
                    sr  <= '0;
                    cnt <= '0;
                end
            end else if (in_valid) begin
                sr  <= word;
                cnt <= complete ? '0 : cnt + CW'(1);
            end

            if (complete) begin
                if (buf_free) begin
                    word_buf <= word;
                    valid_q  <= 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (drain) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_out  = word_buf;
    assign out_valid = valid_q;
    assign overflow  = overflow_q;
    assign busy      = (cnt != '0);

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         serial_in = 1'b0;
    logic         in_valid = 1'b0;
    logic         sync = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] data_out;
    logic         out_valid;
    logic         busy;
    logic         overflow;

    sipo_deserializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .serial_in (serial_in),
        .in_valid  (in_valid),
        .sync      (sync),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: words are assembled arithmetically; the expected
    // buffer content is a queue of at most one word.
    int           m_bits = 0;
    int           m_val  = 0;
    bit           m_ovf  = 1'b0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Applies the effect of the edge that just occurred, using the inputs
    // that were held stable across it.
    task automatic model_edge();
        bit done;
        int w;
        done = 1'b0;
        w    = 0;
        if (!reset) begin
            m_bits = 0;
            m_val  = 0;
            m_ovf  = 1'b0;
            exp_q.delete();
        end else begin
            if (sync) begin
                m_bits = in_valid ? 1 : 0;
                m_val  = in_valid ? int'(serial_in) : 0;
            end else if (in_valid) begin
                m_val  = m_val * 2 + int'(serial_in);
                m_bits = m_bits + 1;
                if (m_bits == W) begin
                    done   = 1'b1;
                    w      = m_val;
                    m_bits = 0;
                    m_val  = 0;
                end
            end
            // The monitor has already popped a word handshaken on this edge.
            if (done) begin
                if (exp_q.size() == 0) exp_q.push_back(W'(w));
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic cyc(input bit s, input bit iv, input bit sy, input bit rdy, input bit rst_n = 1'b1);
        serial_in = s;
        in_valid  = iv;
        sync      = sy;
        out_ready = rdy;
        reset     = rst_n;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send_word(input int v, input bit rdy);
        for (int i = W - 1; i >= 0; i--) cyc(v[i], 1'b1, 1'b0, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, rdy);
    endtask

    // Monitor: samples at the falling edge, where out_valid is the registered
    // value and out_ready is the value the next rising edge will see.
    always @(negedge clk) begin
        if (reset) begin
            chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
            chk("busy", int'(busy), int'(m_bits != 0));
            chk("overflow", int'(overflow), int'(m_ovf));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", int'(data_out), -1);
                end else begin
                    chk("data_out", int'(data_out), int'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #1;
        cyc(0, 0, 0, 0, 1'b0);
        cyc(0, 0, 0, 0, 1'b0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overflow", int'(overflow), 0);

        // Basic word 1011 with a ready consumer
        cyc(1, 1, 0, 1);
        chk("basic_busy", int'(busy), 1);
        cyc(0, 1, 0, 1);
        cyc(1, 1, 0, 1);
        cyc(1, 1, 0, 1);
        chk("basic_word", int'(data_out), 4'b1011);
        chk("basic_valid", int'(out_valid), 1);
        idle(1, 1);
        chk("basic_valid_fall", int'(out_valid), 0);

        // Gapped 0110
        cyc(0, 1, 0, 1); idle(2, 1);
        cyc(1, 1, 0, 1); idle(1, 1);
        cyc(1, 1, 0, 1); idle(3, 1);
        chk("gap_no_early_valid", int'(out_valid), 0);
        cyc(0, 1, 0, 0);
        chk("gap_word", int'(data_out), 4'b0110);
        idle(1, 1);
        idle(1, 1);

        // Back-pressure and overflow
        send_word(4'b1001, 0);
        send_word(4'b0011, 0);
        idle(2, 0);
        chk("bp_hold", int'(data_out), 4'b1001);
        chk("bp_ovf", int'(overflow), 1);
        idle(1, 1);
        idle(3, 0);
        chk("bp_drained", int'(out_valid), 0);

        // Simultaneous drain and fill
        cyc(0, 0, 0, 0, 1'b0);
        send_word(4'b1100, 0);
        idle(2, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 1);
        chk("df_valid", int'(out_valid), 1);
        chk("df_word", int'(data_out), 4'b0101);
        chk("df_ovf", int'(overflow), 0);
        idle(2, 1);

        // Resync with a bit, then resync without one
        cyc(1, 1, 0, 1);
        cyc(1, 1, 0, 1);
        cyc(0, 1, 1, 1);
        cyc(1, 1, 0, 1);
        cyc(1, 1, 0, 1);
        cyc(0, 1, 0, 1);
        chk("sync_word", int'(data_out), 4'b0110);
        idle(1, 1);
        cyc(1, 1, 0, 1);
        cyc(0, 1, 0, 1);
        cyc(1, 1, 0, 1);
        cyc(0, 0, 1, 1);
        chk("sync_busy", int'(busy), 0);
        idle(3, 1);
        chk("sync_no_word", int'(out_valid), 0);

        // Reset mid-operation with a buffered word and overflow set
        send_word(4'b1110, 0);
        send_word(4'b0001, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0, 1'b0);
        chk("mid_rst_data", int'(data_out), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ovf", int'(overflow), 0);
        send_word(4'b0111, 1);
        chk("fresh_word", int'(data_out), 4'b0111);
        idle(2, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit rdy;
            rdy = ((i / 64) % 3 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            cyc($urandom_range(0, 1), $urandom_range(0, 3) != 0,
                $urandom_range(0, 40) == 0, rdy, $urandom_range(0, 700) != 0);
        end
        idle(4, 1);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
